// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/scoreboard unit: redirect codes, result
// select encodings and the register index type.
package hazard_pkg;

  typedef logic [4:0] regidx_t;

  localparam logic [2:0] PC_SEQ  = 3'b000;
  localparam logic [2:0] PC_BR   = 3'b001;
  localparam logic [2:0] PC_JAL  = 3'b010;
  localparam logic [2:0] PC_PRED = 3'b011;
  localparam logic [2:0] PC_JALR = 3'b100;

  localparam logic [2:0] RES_LOAD = 3'b100;

  // Codes that redirect fetch and therefore kill everything younger than B.
  function automatic logic is_redirect(input logic [2:0] pc_src);
    return (pc_src == PC_BR) || (pc_src == PC_JAL) || (pc_src == PC_JALR);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-register scoreboard, outstanding long-op count and stuck-op watchdog
// for the out-of-order long-latency unit.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  regidx_t          issue_rd,
  input  logic             done,
  input  regidx_t          done_rd,
  output logic [NREGS-1:0] pending,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]    count;
  logic [WW-1:0]    wd;
  logic [NREGS-1:0] pending_next;
  logic             done_valid;
  logic             up;
  logic             down;

  assign done_valid = done && (count != '0);
  assign up         = issue_valid && !done_valid && (count != CW'(DEPTH));
  assign down       = done_valid && !issue_valid;
  assign busy       = (count == CW'(DEPTH));

  // Set after clear so a fresh issue to a register still in flight wins.
  always_comb begin
    pending_next = pending;
    if (done_valid) pending_next[done_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_next;
      if (up) count <= count + 1'b1;
      else if (down) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd    <= '0;
      error <= 1'b0;
    end else begin
      if ((count == '0) || done) wd <= '0;
      else if (wd != WW'(TIMEOUT)) wd <= wd + 1'b1;
      if ((count != '0) && !done && (wd == WW'(TIMEOUT - 1))) error <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: N-source forwarding, load-use and scoreboard stalls,
// redirect flushes and saturating stall/flush performance counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NSRC    = 3,
  parameter int NREGS   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16,
  localparam int FWDW   = $clog2(NSRC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  regidx_t           Rs1D,
  input  regidx_t           Rs2D,
  input  regidx_t           RdD,
  input  logic              RegWriteD,
  input  logic              LongOpD,
  input  regidx_t           Rs1E,
  input  regidx_t           Rs2E,
  input  regidx_t           RdE,
  input  logic [2:0]        ResultSrcE,
  input  logic [2:0]        ResultSrcB,
  input  regidx_t           RdB,
  input  logic              LongIssueE,
  input  logic [NSRC*5-1:0] FwdRd,
  input  logic [NSRC-1:0]   FwdRegWrite,
  input  logic              LongDone,
  input  regidx_t           LongDoneRd,
  input  logic [2:0]        PCSrcB,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushB,
  output logic [FWDW-1:0]   ForwardAE,
  output logic [FWDW-1:0]   ForwardBE,
  output logic              LongKill,
  output logic              LongBusy,
  output logic              Error,
  output logic [CNTW-1:0]   StallCycles,
  output logic [CNTW-1:0]   FlushEvents
);

  logic [NREGS-1:0] pending;
  logic c_stall;
  logic d_stall;
  logic l_stall;
  logic sb_stall;
  logic hold;

  // Walk from oldest to youngest so the youngest matching source is left last.
  always_comb begin
    ForwardAE = '0;
    ForwardBE = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (FwdRegWrite[i] && (FwdRd[i*5 +: 5] == Rs1E) && (Rs1E != '0))
        ForwardAE = FWDW'(i + 1);
      if (FwdRegWrite[i] && (FwdRd[i*5 +: 5] == Rs2E) && (Rs2E != '0))
        ForwardBE = FWDW'(i + 1);
    end
  end

  assign c_stall = is_redirect(PCSrcB);
  assign d_stall = (PCSrcB == PC_PRED);

  assign l_stall = ((ResultSrcE == RES_LOAD) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)))
                || ((ResultSrcB == RES_LOAD) && (RdB != '0) && ((RdB == Rs1D) || (RdB == Rs2D)));

  assign sb_stall = ((Rs1D != '0) && pending[Rs1D])
                 || ((Rs2D != '0) && pending[Rs2D])
                 || (RegWriteD && (RdD != '0) && pending[RdD])
                 || (LongIssueE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD)))
                 || (LongOpD && LongBusy);

  assign hold     = (l_stall || sb_stall) && !c_stall;
  assign StallF   = hold;
  assign StallD   = hold;
  assign FlushE   = hold || c_stall;
  assign FlushD   = c_stall || d_stall;
  assign FlushB   = c_stall;
  assign LongKill = LongIssueE && c_stall;

  hazard_scoreboard #(
    .NREGS  (NREGS),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_valid(LongIssueE && !c_stall),
    .issue_rd   (RdE),
    .done       (LongDone),
    .done_rd    (LongDoneRd),
    .pending    (pending),
    .busy       (LongBusy),
    .error      (Error)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallD && (StallCycles != '1)) StallCycles <= StallCycles + 1'b1;
      if (FlushB && (FlushEvents != '1)) FlushEvents <= FlushEvents + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: vector table for the combinational paths, directed
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_hazard_scoreboard_unit;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int CNTW    = 6;
  localparam int CMAX    = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdB, LongDoneRd;
  logic RegWriteD, LongOpD, LongIssueE, LongDone;
  logic [2:0] ResultSrcE, ResultSrcB, PCSrcB;
  logic [14:0] FwdRd;
  logic [2:0] FwdRegWrite;
  logic StallF, StallD, FlushD, FlushE, FlushB, LongKill, LongBusy, Error;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNTW-1:0] StallCycles, FlushEvents;

  int testsRun = 0;
  int testsFailed = 0;

  hazard_scoreboard_unit #(
    .NSRC(3), .NREGS(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .LongOpD(LongOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .ResultSrcB(ResultSrcB),
    .RdB(RdB), .LongIssueE(LongIssueE), .FwdRd(FwdRd), .FwdRegWrite(FwdRegWrite),
    .LongDone(LongDone), .LongDoneRd(LongDoneRd), .PCSrcB(PCSrcB),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .FlushB(FlushB),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LongKill(LongKill), .LongBusy(LongBusy),
    .Error(Error), .StallCycles(StallCycles), .FlushEvents(FlushEvents)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1e;
    logic [4:0]  rs2e;
    logic [14:0] fwdRd;
    logic [2:0]  fwdWe;
    logic [4:0]  rdE;
    logic [2:0]  resE;
    logic [4:0]  rs2d;
    logic [2:0]  pcsrc;
    logic [1:0]  expA;
    logic [1:0]  expB;
    logic        expStall;
    logic        expFlushD;
    logic        expFlushE;
    logic        expFlushB;
  } vec_t;

  vec_t vecs[13];

  // Reference model state: which registers await a long op, how many are out.
  bit mPend[32];
  int mCnt, mWd, mStall, mFlush;
  bit mErr;
  int eFwdA, eFwdB;
  bit eStall, eFlushD, eFlushE, eFlushB, eKill, eBusy;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; LongOpD = 0;
    Rs1E = 0; Rs2E = 0; RdE = 0; ResultSrcE = 0; ResultSrcB = 0; RdB = 0;
    LongIssueE = 0; FwdRd = 0; FwdRegWrite = 0; LongDone = 0; LongDoneRd = 0; PCSrcB = 0;
  endtask

  task automatic modelReset();
    foreach (mPend[i]) mPend[i] = 0;
    mCnt = 0; mWd = 0; mErr = 0; mStall = 0; mFlush = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    modelReset();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int modelFwd(input logic [4:0] rs);
    for (int i = 0; i < 3; i++)
      if (FwdRegWrite[i] && FwdRd[i*5 +: 5] == rs && rs != 0) return i + 1;
    return 0;
  endfunction

  task automatic modelOutputs();
    bit redirect, predFlush, loadUse, scoreHit;
    redirect  = (PCSrcB == 3'b001) || (PCSrcB == 3'b010) || (PCSrcB == 3'b100);
    predFlush = (PCSrcB == 3'b011);
    loadUse   = (ResultSrcE == 3'b100 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D))
             || (ResultSrcB == 3'b100 && RdB != 0 && (RdB == Rs1D || RdB == Rs2D));
    scoreHit  = (Rs1D != 0 && mPend[Rs1D]) || (Rs2D != 0 && mPend[Rs2D])
             || (RegWriteD && RdD != 0 && mPend[RdD])
             || (LongIssueE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D || RdE == RdD))
             || (LongOpD && mCnt == DEPTH);
    eStall  = (loadUse || scoreHit) && !redirect;
    eFlushE = eStall || redirect;
    eFlushD = redirect || predFlush;
    eFlushB = redirect;
    eKill   = LongIssueE && redirect;
    eBusy   = (mCnt == DEPTH);
    eFwdA   = modelFwd(Rs1E);
    eFwdB   = modelFwd(Rs2E);
  endtask

  task automatic modelUpdate();
    bit validIssue, doneOk;
    modelOutputs();
    validIssue = LongIssueE && !eFlushB;
    doneOk     = LongDone && mCnt > 0;
    if (mCnt == 0 || LongDone) mWd = 0;
    else begin
      mWd++;
      if (mWd >= TIMEOUT) mErr = 1;
    end
    if (doneOk) mPend[LongDoneRd] = 0;
    if (validIssue && RdE != 0) mPend[RdE] = 1;
    if (validIssue && !doneOk && mCnt < DEPTH) mCnt++;
    else if (doneOk && !validIssue) mCnt--;
    if (eStall && mStall < CMAX) mStall++;
    if (eFlushB && mFlush < CMAX) mFlush++;
  endtask

  task automatic applyStimulus();
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7)); RdD = 5'($urandom_range(0, 7));
    RegWriteD = 1'($urandom_range(0, 1)); LongOpD = ($urandom_range(0, 9) < 3);
    Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7)); RdE = 5'($urandom_range(0, 7));
    RdB = 5'($urandom_range(0, 7));
    ResultSrcE = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 3));
    ResultSrcB = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 3));
    FwdRd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    FwdRegWrite = 3'($urandom_range(0, 7));
    LongIssueE = (mCnt < DEPTH) && ($urandom_range(0, 3) == 0);
    LongDone = ($urandom_range(0, 9) < 3);
    LongDoneRd = 5'($urandom_range(0, 7));
    PCSrcB = ($urandom_range(0, 9) < 7) ? 3'b000 : 3'($urandom_range(0, 7));
  endtask

  task automatic checkAll();
    checkOutput("rnd.ForwardAE", ForwardAE, eFwdA);
    checkOutput("rnd.ForwardBE", ForwardBE, eFwdB);
    checkOutput("rnd.StallF", StallF, eStall);
    checkOutput("rnd.StallD", StallD, eStall);
    checkOutput("rnd.FlushD", FlushD, eFlushD);
    checkOutput("rnd.FlushE", FlushE, eFlushE);
    checkOutput("rnd.FlushB", FlushB, eFlushB);
    checkOutput("rnd.LongKill", LongKill, eKill);
    checkOutput("rnd.LongBusy", LongBusy, eBusy);
    checkOutput("rnd.Error", Error, mErr);
    checkOutput("rnd.StallCycles", StallCycles, mStall);
    checkOutput("rnd.FlushEvents", FlushEvents, mFlush);
  endtask

  initial begin
    //               rs1e  rs2e  fwdRd                        we      rdE   resE    rs2d  pc      A  B  st fd fe fb
    vecs[0]  = '{5'd5, 5'd0, {5'd5, 5'd5, 5'd5}, 3'b111, 5'd0, 3'b000, 5'd0, 3'b000, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{5'd5, 5'd0, {5'd5, 5'd5, 5'd5}, 3'b110, 5'd0, 3'b000, 5'd0, 3'b000, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{5'd0, 5'd0, {5'd5, 5'd5, 5'd5}, 3'b110, 5'd0, 3'b000, 5'd0, 3'b000, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{5'd9, 5'd6, {5'd9, 5'd6, 5'd5}, 3'b111, 5'd0, 3'b000, 5'd0, 3'b000, 3, 2, 0, 0, 0, 0};
    vecs[4]  = '{5'd9, 5'd6, {5'd9, 5'd6, 5'd5}, 3'b011, 5'd0, 3'b000, 5'd0, 3'b000, 0, 2, 0, 0, 0, 0};
    vecs[5]  = '{5'd5, 5'd5, {5'd9, 5'd6, 5'd5}, 3'b001, 5'd0, 3'b000, 5'd0, 3'b000, 1, 1, 0, 0, 0, 0};
    vecs[6]  = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd7, 3'b100, 5'd7, 3'b000, 0, 0, 1, 0, 1, 0};
    vecs[7]  = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd7, 3'b100, 5'd7, 3'b001, 0, 0, 0, 1, 1, 1};
    vecs[8]  = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd0, 3'b100, 5'd0, 3'b000, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd7, 3'b001, 5'd7, 3'b000, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd0, 3'b000, 5'd0, 3'b011, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd0, 3'b000, 5'd0, 3'b010, 0, 0, 0, 1, 1, 1};
    vecs[12] = '{5'd0, 5'd0, 15'd0,              3'b000, 5'd7, 3'b100, 5'd7, 3'b100, 0, 0, 0, 1, 1, 1};

    doReset();
    @(negedge clk);
    checkOutput("reset.StallCycles", StallCycles, 0);
    checkOutput("reset.FlushEvents", FlushEvents, 0);
    checkOutput("reset.Error", Error, 0);
    checkOutput("reset.LongBusy", LongBusy, 0);
    checkOutput("reset.ForwardAE", ForwardAE, 0);
    checkOutput("reset.StallD", StallD, 0);
    nextCycle();

    for (int v = 0; v < 13; v++) begin
      clearInputs();
      Rs1E = vecs[v].rs1e; Rs2E = vecs[v].rs2e; FwdRd = vecs[v].fwdRd; FwdRegWrite = vecs[v].fwdWe;
      RdE = vecs[v].rdE; ResultSrcE = vecs[v].resE; Rs2D = vecs[v].rs2d; PCSrcB = vecs[v].pcsrc;
      @(negedge clk);
      checkOutput($sformatf("vec%0d.ForwardAE", v), ForwardAE, vecs[v].expA);
      checkOutput($sformatf("vec%0d.ForwardBE", v), ForwardBE, vecs[v].expB);
      checkOutput($sformatf("vec%0d.StallF", v), StallF, vecs[v].expStall);
      checkOutput($sformatf("vec%0d.StallD", v), StallD, vecs[v].expStall);
      checkOutput($sformatf("vec%0d.FlushD", v), FlushD, vecs[v].expFlushD);
      checkOutput($sformatf("vec%0d.FlushE", v), FlushE, vecs[v].expFlushE);
      checkOutput($sformatf("vec%0d.FlushB", v), FlushB, vecs[v].expFlushB);
      nextCycle();
    end

    // Scoreboard RAW stall held until the long op writes back.
    doReset();
    LongIssueE = 1; RdE = 9;
    nextCycle();
    clearInputs();
    Rs1D = 9;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin LongDone = 1; LongDoneRd = 9; end
      @(negedge clk);
      checkOutput($sformatf("raw.StallD.c%0d", c), StallD, 1);
      nextCycle();
    end
    LongDone = 0;
    @(negedge clk);
    checkOutput("raw.StallD.released", StallD, 0);
    checkOutput("raw.StallCycles", StallCycles, 5);
    checkOutput("raw.FlushEvents", FlushEvents, 0);
    nextCycle();

    // Fill the long unit, then watch LongBusy and the LongOpD stall.
    doReset();
    for (int r = 1; r <= 4; r++) begin
      LongIssueE = 1; RdE = 5'(r);
      nextCycle();
    end
    clearInputs();
    LongOpD = 1; LongDone = 1; LongDoneRd = 1;
    @(negedge clk);
    checkOutput("busy.LongBusy.full", LongBusy, 1);
    checkOutput("busy.StallD.full", StallD, 1);
    nextCycle();
    LongDone = 0;
    @(negedge clk);
    checkOutput("busy.LongBusy.after", LongBusy, 0);
    checkOutput("busy.StallD.after", StallD, 0);
    nextCycle();

    // Issue killed by a redirect must leave no trace in the scoreboard.
    doReset();
    LongIssueE = 1; RdE = 3; PCSrcB = 3'b100;
    @(negedge clk);
    checkOutput("kill.LongKill", LongKill, 1);
    checkOutput("kill.FlushE", FlushE, 1);
    nextCycle();
    clearInputs();
    Rs1D = 3;
    @(negedge clk);
    checkOutput("kill.StallD", StallD, 0);
    checkOutput("kill.FlushEvents", FlushEvents, 1);
    nextCycle();
    clearInputs();
    for (int r = 10; r <= 12; r++) begin
      LongIssueE = 1; RdE = 5'(r);
      @(negedge clk);
      checkOutput($sformatf("kill.LongKill.x%0d", r), LongKill, 0);
      nextCycle();
    end
    clearInputs();
    @(negedge clk);
    checkOutput("kill.LongBusy.three", LongBusy, 0);
    nextCycle();
    LongIssueE = 1; RdE = 13;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkOutput("kill.LongBusy.four", LongBusy, 1);
    nextCycle();

    // Watchdog, stickiness, and asynchronous reset in the middle of a cycle.
    doReset();
    LongIssueE = 1; RdE = 5;
    nextCycle();
    clearInputs();
    repeat (TIMEOUT - 1) nextCycle();
    @(negedge clk);
    checkOutput("wd.Error.early", Error, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("wd.Error.set", Error, 1);
    LongDone = 1; LongDoneRd = 5;
    nextCycle();
    clearInputs();
    @(negedge clk);
    checkOutput("wd.Error.sticky", Error, 1);
    nextCycle();
    LongIssueE = 1; RdE = 6;
    nextCycle();
    clearInputs();
    Rs1D = 6;
    @(negedge clk);
    checkOutput("wd.StallD.pending", StallD, 1);
    #2 rst_n = 0;
    #1;
    checkOutput("wd.reset.Error", Error, 0);
    checkOutput("wd.reset.StallD", StallD, 0);
    checkOutput("wd.reset.StallCycles", StallCycles, 0);
    checkOutput("wd.reset.LongBusy", LongBusy, 0);
    @(posedge clk);
    #1 rst_n = 1;
    clearInputs();
    LongDone = 1; LongDoneRd = 6;
    nextCycle();
    clearInputs();
    for (int r = 1; r <= 4; r++) begin
      LongIssueE = 1; RdE = 5'(r);
      nextCycle();
    end
    clearInputs();
    @(negedge clk);
    checkOutput("wd.lateDone.LongBusy", LongBusy, 1);
    nextCycle();

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      modelOutputs();
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelUpdate();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
